// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// reset defaults and address helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // Branch targets are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that adds 0..2 per cycle and sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  inc,
  output logic [15:0] count
);

  logic [15:0] count_reg;
  logic [16:0] sum;

  assign sum   = {1'b0, count_reg} + {15'b0, inc};
  assign count = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= 16'h0000;
    else
      count_reg <= sum[16] ? 16'hFFFF : sum[15:0];
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register from a
// combinational ROM and sequences stall, redirect, halt and drain.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          ROM_WORDS    = 256,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        HaltReq,
  output logic [31:0] RomAddr,
  input  logic [31:0] RomInst,
  output logic [31:0] IfIdInst,
  output logic [31:0] IfIdPC4,
  output logic        IfIdValid,
  output logic [1:0]  State,
  output logic [15:0] FetchCount,
  output logic [15:0] FlushCount
);

  localparam int          DW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [29:0] ROM_LIMIT = 30'(ROM_WORDS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  fetch_state_t    state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [31:0]     ifid_inst_reg, ifid_inst_next;
  logic [31:0]     ifid_pc4_reg, ifid_pc4_next;
  logic            ifid_valid_reg, ifid_valid_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [1:0]      fetch_inc, flush_inc;
  logic [31:0]     pc_plus4;
  logic [31:0]     target_pc;

  assign pc_plus4  = pc_reg + 32'd4;
  assign target_pc = word_align(RedirectPC);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      ifid_inst_reg  <= NOP_WORD;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
      drain_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_inst_reg  <= ifid_inst_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
      drain_cnt_reg  <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_inst_next  = ifid_inst_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    drain_cnt_next  = drain_cnt_reg;
    fetch_inc       = 2'd0;
    flush_inc       = 2'd0;
    case (state_reg)
      ST_IDLE: begin
        ifid_valid_next = 1'b0;
        if (Start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (Redirect) begin
          // Squash the slot being fetched now plus whatever sits in IF/ID.
          pc_next         = target_pc;
          ifid_inst_next  = NOP_WORD;
          ifid_pc4_next   = 32'h0;
          ifid_valid_next = 1'b0;
          flush_inc       = ifid_valid_reg ? 2'd2 : 2'd1;
        end else if (Stall) begin
          state_next = ST_RUN;
        end else if (HaltReq || (pc_reg[31:2] >= ROM_LIMIT)) begin
          state_next      = ST_DRAIN;
          ifid_valid_next = 1'b0;
          drain_cnt_next  = '0;
        end else begin
          ifid_inst_next  = RomInst;
          ifid_pc4_next   = pc_plus4;
          ifid_valid_next = 1'b1;
          pc_next         = pc_plus4;
          fetch_inc       = 2'd1;
        end
      end
      ST_DRAIN: begin
        ifid_valid_next = 1'b0;
        // An older in-flight branch may still pull us back into the ROM.
        if (Redirect && !HaltReq && (RedirectPC[31:2] < ROM_LIMIT)) begin
          state_next     = ST_RUN;
          pc_next        = target_pc;
          drain_cnt_next = '0;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = ST_HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      default: begin
        ifid_valid_next = 1'b0;
      end
    endcase
  end

  sat_counter16 u_fetch_count (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (fetch_inc),
    .count (FetchCount)
  );

  sat_counter16 u_flush_count (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (flush_inc),
    .count (FlushCount)
  );

  assign RomAddr   = pc_reg;
  assign IfIdInst  = ifid_inst_reg;
  assign IfIdPC4   = ifid_pc4_reg;
  assign IfIdValid = ifid_valid_reg;
  assign State     = state_reg;

endmodule
